// File: rtl/piso_pkg.sv
// Shared types and sizing for the piso_serializer transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  // Counter width able to hold every frame position, parity bit included.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: tracks the position of the bit currently on the serial line.
module piso_bit_counter #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last_c,
  output logic penult_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // penult_c lets the owner register DONE so it lands on the last bit.
  assign last_c   = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign penult_c = (cnt_q == CNT_W'(FRAME_LEN - 2));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless streaming.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             svalid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, last_c, penult_c;
  logic             ready_c, accept_c;
  logic             load_bit_c, shift_bit_c, next_bit_c;
  logic [WIDTH-1:0] load_rest_c, shift_rest_c;

  piso_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .last_c   (last_c),
    .penult_c (penult_c)
  );

  assign ready_c  = (state_q == IDLE) || ((state_q == SHIFT) && last_c);
  assign accept_c = load && ready_c;

  // Shift register holds only the bits not yet sent.
  always_comb begin
    if (LSB_FIRST) begin
      load_bit_c   = pdata[0];
      load_rest_c  = pdata >> 1;
      shift_bit_c  = shreg_q[0];
      shift_rest_c = shreg_q >> 1;
    end else begin
      load_bit_c   = pdata[WIDTH-1];
      load_rest_c  = pdata << 1;
      shift_bit_c  = shreg_q[WIDTH-1];
      shift_rest_c = shreg_q << 1;
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = accept_c ? (^pdata) : parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // After the last data bit the parity bit goes out.
  assign next_bit_c = penult_c ? parity_q : shift_bit_c;
`else
  assign next_bit_c = shift_bit_c;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    sout_d   = sout_q;
    svalid_d = svalid_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (accept_c) begin
      state_d  = SHIFT;
      shreg_d  = load_rest_c;
      sout_d   = load_bit_c;
      svalid_d = 1'b1;
      cnt_clr  = 1'b1;
    end else if (state_q == SHIFT) begin
      if (last_c) begin
        state_d  = IDLE;
        shreg_d  = '0;
        sout_d   = 1'b0;
        svalid_d = 1'b0;
        cnt_clr  = 1'b1;
      end else begin
        shreg_d = shift_rest_c;
        sout_d  = next_bit_c;
        cnt_en  = 1'b1;
        done_d  = penult_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_c;
  assign sout   = sout_q;
  assign svalid = svalid_q;
  assign done   = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pdata;
  logic       load;
  logic       ready_a, sout_a, svalid_a, done_a;
  logic       ready_b, sout_b, svalid_b, done_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk    (clk),
    .rst_n  (rst_n),
    .pdata  (pdata),
    .load   (load),
    .ready  (ready_a),
    .sout   (sout_a),
    .svalid (svalid_a),
    .done   (done_a)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk    (clk),
    .rst_n  (rst_n),
    .pdata  (pdata),
    .load   (load),
    .ready  (ready_b),
    .sout   (sout_b),
    .svalid (svalid_b),
    .done   (done_b)
  );

  // Expected sequences written in transmit order, first bit in position 3.
  typedef struct {
    logic [3:0] pdata;
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       par;
  } vec_t;

  vec_t tbl [7];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input int idx, input int i, input bit lsb);
    logic [3:0] s;
    s = lsb ? tbl[idx].lsb : tbl[idx].msb;
    if (i < 4) return s[3-i];
    return tbl[idx].par;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input int idx, input int i);
    chk({tag, ".sout_msb"}, sout_a, frame_bit(idx, i, 1'b0));
    chk({tag, ".sout_lsb"}, sout_b, frame_bit(idx, i, 1'b1));
    chk({tag, ".svalid"}, svalid_a, 1'b1);
    chk({tag, ".svalid_lsb"}, svalid_b, 1'b1);
    chk({tag, ".done"}, done_a, (i == FL - 1));
    chk({tag, ".done_lsb"}, done_b, (i == FL - 1));
    chk({tag, ".ready"}, ready_a, (i == FL - 1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".idle_sout"}, sout_a, 1'b0);
    chk({tag, ".idle_svalid"}, svalid_a, 1'b0);
    chk({tag, ".idle_done"}, done_a, 1'b0);
    chk({tag, ".idle_ready"}, ready_a, 1'b1);
    chk({tag, ".idle_sout_lsb"}, sout_b, 1'b0);
    chk({tag, ".idle_svalid_lsb"}, svalid_b, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int idx);
    pdata = tbl[idx].pdata;
    load  = 1'b1;
    chk({tag, ".ready_pre"}, ready_a, 1'b1);
    step();
    load  = 1'b0;
    pdata = 4'($urandom);
    for (int i = 0; i < FL; i++) begin
      check_bit(tag, idx, i);
      step();
    end
    check_idle(tag);
  endtask

  initial begin
    tbl[0] = '{4'b1001, 4'b1001, 4'b1001, 1'b0};
    tbl[1] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
    tbl[2] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
    tbl[3] = '{4'b1110, 4'b1110, 4'b0111, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
    tbl[6] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};

    // Reset held two cycles, then idle with LOAD low.
    rst_n = 1'b0;
    load  = 1'b0;
    pdata = 4'b0000;
    step();
    check_idle("rst_hold1");
    step();
    check_idle("rst_hold2");
    rst_n = 1'b1;
    step();
    check_idle("post_rst1");
    step();
    check_idle("post_rst2");

    // Single frames from the table.
    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("vec%0d", v), v);
      step();
    end

    // Back-to-back: second LOAD in the DONE cycle, no gap.
    pdata = tbl[0].pdata;
    load  = 1'b1;
    step();
    load  = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check_bit("b2b_w0", 0, i);
      if (i == FL - 1) begin
        pdata = tbl[1].pdata;
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end
    for (int i = 0; i < FL; i++) begin
      check_bit("b2b_w1", 1, i);
      step();
    end
    check_idle("b2b_end");
    step();

    // LOAD while busy is ignored and the frame in flight is untouched.
    pdata = tbl[0].pdata;
    load  = 1'b1;
    step();
    load  = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check_bit("busy_load", 0, i);
      if (i == 1) begin
        pdata = 4'b1111;
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end
    check_idle("busy_load_end");
    step();
    check_idle("busy_load_end2");

    // Asynchronous reset mid-frame, then a clean frame.
    pdata = tbl[0].pdata;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check_bit("midrst", 0, 0);
    step();
    check_bit("midrst", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midrst_async");
    @(posedge clk);
    #1;
    check_idle("midrst_held");
    rst_n = 1'b1;
    step();
    check_idle("midrst_rel");
    run_frame("after_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
